// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller: op codes, FSM encoding, default sizes.
// Imported by the interface, the RAM and the controller top.
package stack_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic [1:0] {
    OP_PUSH    = 2'b00,
    OP_POP     = 2'b01,
    OP_PEEK    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RSP  = 3'd3,
    ERR  = 3'd4
  } state_e;

  // POP and PEEK go through the two-cycle RAM read path.
  function automatic logic is_read_op(op_e op);
    return (op == OP_POP) || (op == OP_PEEK);
  endfunction

endpackage

// File: rtl/stack_if.sv
// Request/response handshake between a control unit (master) and the stack controller (slave).
// Status and sticky-error signals stay as plain ports on the controller.
interface stack_if import stack_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid,
    output req_op,
    output req_data,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_data,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );

endinterface

// File: rtl/stack_ram.sv
// Single-port synchronous stack storage with a registered read port (1-cycle read latency).
// Array contents are not reset; only the read register is.
module stack_ram import stack_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage write port.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read of the addressed word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/stack_ctrl.sv
// Hardware stack controller: PUSH/POP/PEEK/REPLACE over a single-port RAM, one request
// in flight at a time, with sticky overflow/underflow flags.
module stack_ctrl import stack_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic            clock,
  input  logic            reset,
  stack_if.slave          bus,
  input  logic            err_clear,
  output logic [ADDR_W:0] count,
  output logic            empty,
  output logic            full,
  output logic            err_overflow,
  output logic            err_underflow
);

  localparam logic [ADDR_W:0]   DEPTH_C    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   SP_ZERO_C  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   SP_ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE_C = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_r, state_s;
  op_e               op_r, op_s, req_op_s;
  logic [DATA_W-1:0] data_r, data_s;
  logic [ADDR_W:0]   sp_r, sp_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic              rsp_err_r, rsp_err_s;
  logic [DATA_W-1:0] rsp_data_r, rsp_data_s;
  logic              err_ovf_r, err_ovf_s;
  logic              err_udf_r, err_udf_s;
  logic              set_ovf_s, set_udf_s;
  logic              empty_s, full_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [ADDR_W-1:0] top_addr_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign empty_s    = (sp_r == SP_ZERO_C);
  assign full_s     = (sp_r == DEPTH_C);
  assign top_addr_s = sp_r[ADDR_W-1:0] - ADDR_ONE_C;
  assign req_op_s   = op_e'(bus.req_op);

  // Next-state, RAM control and next response values.
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    data_s      = data_r;
    sp_s        = sp_r;
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_data_s  = {DATA_W{1'b0}};
    set_ovf_s   = 1'b0;
    set_udf_s   = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = top_addr_s;

    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          op_s   = req_op_s;
          data_s = bus.req_data;
          if (req_op_s == OP_PUSH) begin
            if (full_s) begin
              state_s   = ERR;
              set_ovf_s = 1'b1;
            end else begin
              state_s = WR;
            end
          end else if (empty_s) begin
            state_s   = ERR;
            set_udf_s = 1'b1;
          end else if (is_read_op(req_op_s)) begin
            state_s = RD;
          end else begin
            state_s = WR;
          end
          // Responses for WR/ERR are registered on the accept edge so they appear one cycle later.
          if (state_s == WR) begin
            rsp_valid_s = 1'b1;
            rsp_data_s  = bus.req_data;
          end else if (state_s == ERR) begin
            rsp_valid_s = 1'b1;
            rsp_err_s   = 1'b1;
          end else begin
            rsp_valid_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        ram_we_s = 1'b1;
        if (op_r == OP_PUSH) begin
          ram_addr_s = sp_r[ADDR_W-1:0];
          sp_s       = sp_r + SP_ONE_C;
        end else begin
          ram_addr_s = top_addr_s;
        end
        state_s = IDLE;
      end
      RD: begin
        ram_addr_s  = top_addr_s;
        rsp_valid_s = 1'b1;
        state_s     = RSP;
      end
      RSP: begin
        if (op_r == OP_POP) begin
          sp_s = sp_r - SP_ONE_C;
        end else begin
          sp_s = sp_r;
        end
        state_s = IDLE;
      end
      ERR: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sticky error flags: a new error in the same cycle as err_clear keeps the flag set.
  always_comb begin
    if (set_ovf_s) begin
      err_ovf_s = 1'b1;
    end else if (err_clear) begin
      err_ovf_s = 1'b0;
    end else begin
      err_ovf_s = err_ovf_r;
    end
    if (set_udf_s) begin
      err_udf_s = 1'b1;
    end else if (err_clear) begin
      err_udf_s = 1'b0;
    end else begin
      err_udf_s = err_udf_r;
    end
  end

  // Controller state, captured request and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      op_r        <= OP_PUSH;
      data_r      <= {DATA_W{1'b0}};
      sp_r        <= SP_ZERO_C;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      err_ovf_r   <= 1'b0;
      err_udf_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      data_r      <= data_s;
      sp_r        <= sp_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_data_r  <= rsp_data_s;
      err_ovf_r   <= err_ovf_s;
      err_udf_r   <= err_udf_s;
    end
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (data_r),
    .rdata (ram_rdata_s)
  );

  // In RSP the RAM read register is the response data register.
  assign bus.rsp_data  = (state_r == RSP) ? ram_rdata_s : rsp_data_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.req_ready = (state_r == IDLE);

  assign count         = sp_r;
  assign empty         = empty_s;
  assign full          = full_s;
  assign err_overflow  = err_ovf_r;
  assign err_underflow = err_udf_r;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed scenarios plus biased random traffic
// compared against a queue-based stack model.
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          err_clear = 1'b0;
  logic [AW:0]   count;
  logic          empty, full, err_overflow, err_underflow;

  stack_if #(.DATA_W(DW)) bus ();

  stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .err_clear     (err_clear),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] model_q[$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a falling edge; leaves the bench at a falling edge with the DUT idle.
  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0;
    err_clear = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_eq("rst_count",     32'(count), 32'd0);
    check_eq("rst_empty",     32'(empty), 32'd1);
    check_eq("rst_full",      32'(full), 32'd0);
    check_eq("rst_ready",     32'(bus.req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    check_eq("rst_rsp_data",  32'(bus.rsp_data), 32'd0);
    check_eq("rst_ovf",       32'(err_overflow), 32'd0);
    check_eq("rst_udf",       32'(err_underflow), 32'd0);
  endtask

  // Issues one request at the current falling edge and checks timing, data and status.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] d, input logic clr);
    bit            err;
    logic [DW-1:0] exp_data;
    int            lat;
    err      = 1'b0;
    exp_data = '0;
    lat      = 1;
    if (clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    case (op)
      2'b00: begin
        if (model_q.size() == DEPTH) begin
          err = 1'b1;
          m_ovf = 1'b1;
        end else begin
          exp_data = d;
          model_q.push_back(d);
        end
      end
      2'b01, 2'b10: begin
        if (model_q.size() == 0) begin
          err = 1'b1;
          m_udf = 1'b1;
        end else begin
          lat = 2;
          if (op == 2'b01) exp_data = model_q.pop_back();
          else             exp_data = model_q[model_q.size()-1];
        end
      end
      default: begin
        if (model_q.size() == 0) begin
          err = 1'b1;
          m_udf = 1'b1;
        end else begin
          model_q[model_q.size()-1] = d;
          exp_data = d;
        end
      end
    endcase

    check_eq("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    err_clear     = clr;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    err_clear     = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clock);
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(c == lat));
      if (c < lat) check_eq("rsp_err_rd", 32'(bus.rsp_err), 32'd0);
    end
    check_eq("rsp_err",  32'(bus.rsp_err), 32'(err));
    check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
    check_eq("err_overflow",  32'(err_overflow), 32'(m_ovf));
    check_eq("err_underflow", 32'(err_underflow), 32'(m_udf));
    @(negedge clock);
    check_eq("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    check_eq("count", 32'(count), 32'(model_q.size()));
    check_eq("empty", 32'(empty), 32'(model_q.size() == 0));
    check_eq("full",  32'(full), 32'(model_q.size() == DEPTH));
    check_eq("ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_data  = '0;
    @(negedge clock);
    do_reset();

    // Basic LIFO order, then underflow and clearing.
    issue(2'b00, 8'h11, 1'b0);
    issue(2'b00, 8'h22, 1'b0);
    issue(2'b00, 8'h33, 1'b0);
    check_eq("count_3", 32'(count), 32'd3);
    issue(2'b01, 8'h00, 1'b0);
    issue(2'b01, 8'h00, 1'b0);
    issue(2'b01, 8'h00, 1'b0);
    check_eq("empty_after_pops", 32'(empty), 32'd1);
    issue(2'b01, 8'h00, 1'b0);
    check_eq("udf_set", 32'(err_underflow), 32'd1);
    issue(2'b10, 8'h00, 1'b1);
    issue(2'b00, 8'h44, 1'b1);
    check_eq("udf_cleared", 32'(err_underflow), 32'd0);
    issue(2'b01, 8'h00, 1'b0);

    // Fill to capacity, overflow, then peek the last stored value.
    for (int i = 0; i < DEPTH; i++) issue(2'b00, 8'(8'h40 + i), 1'b0);
    check_eq("full_32", 32'(full), 32'd1);
    issue(2'b00, 8'hAA, 1'b0);
    check_eq("ovf_set", 32'(err_overflow), 32'd1);
    issue(2'b10, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) issue(2'b01, 8'h00, 1'b0);

    // REPLACE and set-wins on coincident clear.
    do_reset();
    issue(2'b00, 8'h05, 1'b0);
    issue(2'b11, 8'h09, 1'b0);
    issue(2'b10, 8'h00, 1'b0);
    check_eq("count_1", 32'(count), 32'd1);
    issue(2'b01, 8'h00, 1'b0);
    issue(2'b11, 8'h77, 1'b1);
    check_eq("udf_set_wins", 32'(err_underflow), 32'd1);

    // Reset while a POP is in its RAM-read cycle.
    issue(2'b00, 8'h5A, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_eq("abort_no_rsp0", 32'(bus.rsp_valid), 32'd0);
    @(negedge clock);
    check_eq("abort_no_rsp1", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clock);
    check_eq("abort_no_rsp2", 32'(bus.rsp_valid), 32'd0);
    check_eq("abort_count",   32'(count), 32'd0);
    check_eq("abort_ready",   32'(bus.req_ready), 32'd1);

    // Biased random traffic alternating between filling and draining phases.
    for (int ph = 0; ph < 6; ph++) begin
      int bias;
      bias = (ph % 2 == 0) ? 75 : 20;
      for (int n = 0; n < 120; n++) begin
        logic [1:0] op;
        if ($urandom_range(0, 99) < bias) op = 2'b00;
        else op = 2'($urandom_range(1, 3));
        issue(op, 8'($urandom), ($urandom_range(0, 7) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
